station_cook_ctrl: RTL

- Parametrised successor to the single onion-station containment check.
- Handles N stations: per-station occupancy detection, a dispenser or cooker role per station, and a per-cooker cook/burn timer FSM.
- Tracks the item the character holds (EMPTY/RAW/COOKED).
- Sits between the character-movement logic and the drawing/LED logic. Drawing modules read its state outputs.

---
 rtl/station_cook_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/station_cook_ctrl.sv
// Station controller: per-station occupancy, dispenser/cooker roles, per-cooker cook/burn timers
// and the item held by the character.
module station_cook_ctrl #(
    parameter int unsigned                N_STATIONS     = 4,
    parameter logic [N_STATIONS*7-1:0]    STATION_X      = {7'd81, 7'd32, 7'd32, 7'd3},
    parameter logic [N_STATIONS*7-1:0]    STATION_Y      = {7'd16, 7'd49, 7'd3, 7'd3},
    parameter int unsigned                LENGTH         = 12,
    parameter int unsigned                WIDTH          = 12,
    parameter logic [N_STATIONS-1:0]      DISPENSER_MASK = 4'b0001,
    parameter int unsigned                COOK_TICKS     = 8,
    parameter int unsigned                BURN_TICKS     = 12
) (
    input  logic                      clk_25MHz,
    input  logic                      rst_n,
    input  logic [6:0]                character_x_left,
    input  logic [6:0]                character_x_right,
    input  logic [6:0]                character_y_top,
    input  logic [6:0]                character_y_bot,
    input  logic                      interact,
    input  logic                      tick,
    input  logic                      held_clear,
    output logic [N_STATIONS-1:0]     in_station,
    output logic                      led,
    output logic [1:0]                held,
    output logic [2*N_STATIONS-1:0]   station_state,
    output logic [N_STATIONS-1:0]     done_pulse,
    output logic [N_STATIONS-1:0]     burn_pulse
);

    localparam int unsigned MAX_TICKS = (COOK_TICKS > BURN_TICKS) ? COOK_TICKS : BURN_TICKS;
    localparam int unsigned CW        = $clog2(MAX_TICKS + 1);
    localparam int unsigned IW        = (N_STATIONS > 1) ? $clog2(N_STATIONS) : 1;
    localparam logic [CW-1:0] COOK_LAST = CW'(COOK_TICKS - 1);
    localparam logic [CW-1:0] BURN_LAST = CW'((BURN_TICKS > 0) ? BURN_TICKS - 1 : 0);

    typedef enum logic [1:0] {StIdle = 2'b00, StCooking = 2'b01, StDone = 2'b10, StBurnt = 2'b11}
        station_e;
    typedef enum logic [1:0] {HeldEmpty = 2'b00, HeldRaw = 2'b01, HeldCooked = 2'b10} held_e;

    station_e              state_q [N_STATIONS];
    station_e              state_d [N_STATIONS];
    logic [CW-1:0]         cnt_q   [N_STATIONS];
    logic [CW-1:0]         cnt_d   [N_STATIONS];
    held_e                 held_q, held_d;
    logic [N_STATIONS-1:0] done_q, done_d, burn_q, burn_d;
    logic [IW-1:0]         active_idx;

    // Compare at 8 bits so that the far edge of a station near x=127 cannot wrap.
    for (genvar g = 0; g < N_STATIONS; g++) begin : g_station
        logic [7:0] sx, sy;
        assign sx = {1'b0, STATION_X[7*g +: 7]};
        assign sy = {1'b0, STATION_Y[7*g +: 7]};
        assign in_station[g] = ({1'b0, character_x_left}  >= sx) &&
                               ({1'b0, character_x_right} <= sx + 8'(LENGTH - 1)) &&
                               ({1'b0, character_y_top}   >= sy) &&
                               ({1'b0, character_y_bot}   <= sy + 8'(WIDTH - 1));
        assign station_state[2*g +: 2] = state_q[g];
    end

    assign led        = |in_station;
    assign held       = held_q;
    assign done_pulse = done_q;
    assign burn_pulse = burn_q;

    always_comb begin
        active_idx = '0;
        for (int i = N_STATIONS - 1; i >= 0; i--) begin
            if (in_station[i]) active_idx = IW'(i);
        end
    end

    always_comb begin
        held_d = held_q;
        done_d = '0;
        burn_d = '0;
        for (int i = 0; i < N_STATIONS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end

        for (int i = 0; i < N_STATIONS; i++) begin
            if (DISPENSER_MASK[i]) begin
                state_d[i] = StIdle;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    StCooking: begin
                        if (tick) begin
                            if (cnt_q[i] == COOK_LAST) begin
                                state_d[i] = StDone;
                                cnt_d[i]   = '0;
                                done_d[i]  = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        if (BURN_TICKS > 0 && tick) begin
                            if (cnt_q[i] == BURN_LAST) begin
                                state_d[i] = StBurnt;
                                cnt_d[i]   = '0;
                                burn_d[i]  = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] + 1'b1;
                            end
                        end
                    end
                    default: cnt_d[i] = '0;
                endcase
            end
        end

        // Interaction overrides the timer only for a DONE pickup; a COOKING tick always stands.
        if (held_clear) begin
            held_d = HeldEmpty;
        end else if (interact && led) begin
            if (DISPENSER_MASK[active_idx]) begin
                if (held_q == HeldEmpty)    held_d = HeldRaw;
                else if (held_q == HeldRaw) held_d = HeldEmpty;
            end else begin
                case (state_q[active_idx])
                    StIdle: begin
                        if (held_q == HeldRaw) begin
                            state_d[active_idx] = StCooking;
                            cnt_d[active_idx]   = '0;
                            held_d              = HeldEmpty;
                        end
                    end
                    StDone: begin
                        if (held_q == HeldEmpty) begin
                            held_d              = HeldCooked;
                            state_d[active_idx] = StIdle;
                            cnt_d[active_idx]   = '0;
                            burn_d[active_idx]  = 1'b0;
                        end
                    end
                    StBurnt: begin
                        if (held_q == HeldEmpty) state_d[active_idx] = StIdle;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= HeldEmpty;
            done_q <= '0;
            burn_q <= '0;
            for (int i = 0; i < N_STATIONS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
        end else begin
            held_q <= held_d;
            done_q <= done_d;
            burn_q <= burn_d;
            for (int i = 0; i < N_STATIONS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

endmodule
